spike_gen_prog_assembler: RTL and testbench

- Upstream stage of the spike generator array.
- Takes 18-bit configuration words, one field per word, from the host-side config decoder.
- Assembles them into a single generator programming record {gen_idx, period, ticks, tag}.
- Presents the record on the spike-generator programming channel with a valid/ack handshake. Malformed records are dropped and counted; they never reach the array.

---
 rtl/spike_gen_pkg.sv | 29 ++
 rtl/spike_gen_prog_assembler.sv | 139 +++++++++++++
 tb/tb_spike_gen_prog_assembler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_gen_pkg.sv
// Shared types and constants for the spike generator programming path.
// The record struct is also the generator array's programming interface.
package spike_gen_pkg;

  localparam int NGENS   = 8;
  localparam int NIDX    = $clog2(NGENS);
  localparam int NPERIOD = 16;
  localparam int NTAG    = 11;
  localparam int NERR    = 8;
  localparam int NPAY    = 16;

  localparam logic [1:0] FIELD_IDX        = 2'd0;
  localparam logic [1:0] FIELD_PERIOD     = 2'd1;
  localparam logic [1:0] FIELD_TICKS      = 2'd2;
  localparam logic [1:0] FIELD_TAG_COMMIT = 2'd3;

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_t;

  typedef struct packed {
    logic [NIDX-1:0]    gen_idx;
    logic [NPERIOD-1:0] period;
    logic [NPERIOD-1:0] ticks;
    logic [NTAG-1:0]    tag;
  } spike_gen_prog_t;

endpackage

// File: rtl/spike_gen_prog_assembler.sv
// Collects per-field config words into one generator programming record,
// drops malformed records (counting them) and hands valid ones downstream.
module spike_gen_prog_assembler
  import spike_gen_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_v,
  input  logic [17:0]        in_d,
  output logic               in_a,
  output logic               prog_v,
  output logic [NIDX-1:0]    prog_gen_idx,
  output logic [NPERIOD-1:0] prog_period,
  output logic [NPERIOD-1:0] prog_ticks,
  output logic [NTAG-1:0]    prog_tag,
  input  logic               prog_a,
  output logic               err,
  output logic [NERR-1:0]    err_count
);

  localparam logic [NPAY-1:0] NGENS_W = NPAY'(NGENS);

  state_t            state_q, state_d;
  logic              hold_q;
  logic [NPAY-1:0]   idx_q, idx_d;
  logic [NPERIOD-1:0] period_q, period_d;
  logic [NPERIOD-1:0] ticks_q, ticks_d;
  logic              fi_q, fi_d, fp_q, fp_d, ft_q, ft_d;
  spike_gen_prog_t   rec_q, rec_d;
  logic              err_q, err_d;
  logic [NERR-1:0]   cnt_q, cnt_d;

  logic [1:0]      sel;
  logic [NPAY-1:0] payload;
  logic            word_xfer;
  logic            commit;
  logic            rec_ok;

  assign sel       = in_d[17:16];
  assign payload   = in_d[15:0];
  assign word_xfer = in_v && in_a;
  assign commit    = word_xfer && (sel == FIELD_TAG_COMMIT);

  // Full 16-bit index is kept so out-of-range upper bits can be rejected.
  assign rec_ok = fi_q && fp_q && ft_q
               && (payload[NPAY-1:NTAG] == '0)
               && (idx_q[NPAY-1:NIDX] == '0) && (idx_q < NGENS_W)
               && (period_q != '0)
               && (ticks_q < period_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are reset too, since the outputs must read 0
      // after reset rather than whatever the last record held.
      state_q  <= COLLECT;
      hold_q   <= 1'b1;
      idx_q    <= '0;
      period_q <= '0;
      ticks_q  <= '0;
      fi_q     <= 1'b0;
      fp_q     <= 1'b0;
      ft_q     <= 1'b0;
      rec_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= 1'b0;
      idx_q    <= idx_d;
      period_q <= period_d;
      ticks_q  <= ticks_d;
      fi_q     <= fi_d;
      fp_q     <= fp_d;
      ft_q     <= ft_d;
      rec_q    <= rec_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (commit && rec_ok) state_d = OUT;
      OUT:     if (prog_a)           state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    idx_d    = idx_q;
    period_d = period_q;
    ticks_d  = ticks_q;
    fi_d     = fi_q;
    fp_d     = fp_q;
    ft_d     = ft_q;
    rec_d    = rec_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (word_xfer) begin
      case (sel)
        FIELD_IDX:    begin idx_d    = payload;              fi_d = 1'b1; end
        FIELD_PERIOD: begin period_d = payload[NPERIOD-1:0]; fp_d = 1'b1; end
        FIELD_TICKS:  begin ticks_d  = payload[NPERIOD-1:0]; ft_d = 1'b1; end
        default: begin
          fi_d = 1'b0;
          fp_d = 1'b0;
          ft_d = 1'b0;
          if (rec_ok) begin
            rec_d.gen_idx = idx_q[NIDX-1:0];
            rec_d.period  = period_q;
            rec_d.ticks   = ticks_q;
            rec_d.tag     = payload[NTAG-1:0];
          end else begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Input stays back-pressured for the first cycle out of reset.
  always_comb begin
    in_a   = (state_q == COLLECT) && !hold_q;
    prog_v = (state_q == OUT);
  end

  assign prog_gen_idx = rec_q.gen_idx;
  assign prog_period  = rec_q.period;
  assign prog_ticks   = rec_q.ticks;
  assign prog_tag     = rec_q.tag;
  assign err          = err_q;
  assign err_count    = cnt_q;

endmodule

// File: tb/tb_spike_gen_prog_assembler.sv
// Directed bench for the programming-record assembler: a transaction-level
// model is compared against the DUT every cycle, plus literal spot checks.
module tb_spike_gen_prog_assembler;
  import spike_gen_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_v = 1'b0;
  logic [17:0]        in_d = '0;
  logic               in_a;
  logic               prog_v;
  logic [NIDX-1:0]    prog_gen_idx;
  logic [NPERIOD-1:0] prog_period;
  logic [NPERIOD-1:0] prog_ticks;
  logic [NTAG-1:0]    prog_tag;
  logic               prog_a = 1'b0;
  logic               err;
  logic [NERR-1:0]    err_count;

  always #5 clk = ~clk;

  spike_gen_prog_assembler dut (
    .clk(clk), .reset(reset),
    .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .prog_v(prog_v), .prog_gen_idx(prog_gen_idx), .prog_period(prog_period),
    .prog_ticks(prog_ticks), .prog_tag(prog_tag), .prog_a(prog_a),
    .err(err), .err_count(err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Model: a set of written fields, one optional pending record, an error tally.
  bit          m_have_i = 0, m_have_p = 0, m_have_t = 0;
  int unsigned m_idx = 0, m_per = 0, m_tck = 0;
  bit          m_pending = 0, m_block = 1, m_err = 0;
  int unsigned m_cnt = 0;
  int unsigned r_idx = 0, r_per = 0, r_tck = 0, r_tag = 0;
  bit          started = 0;

  always @(posedge clk) begin : model
    bit          acc;
    int unsigned pay;
    if (reset) begin
      m_have_i = 0; m_have_p = 0; m_have_t = 0;
      m_idx = 0; m_per = 0; m_tck = 0;
      m_pending = 0; m_block = 1; m_err = 0; m_cnt = 0;
      r_idx = 0; r_per = 0; r_tck = 0; r_tag = 0;
    end else begin
      acc = in_v && !m_pending && !m_block;
      pay = in_d[15:0];
      if (m_pending && prog_a) m_pending = 0;
      if (acc) begin
        case (in_d[17:16])
          2'd0: begin m_idx = pay; m_have_i = 1; end
          2'd1: begin m_per = pay; m_have_p = 1; end
          2'd2: begin m_tck = pay; m_have_t = 1; end
          default: begin
            if (m_have_i && m_have_p && m_have_t && pay < 2048 && m_idx < 8
                && m_per != 0 && m_tck < m_per) begin
              r_idx = m_idx; r_per = m_per; r_tck = m_tck; r_tag = pay;
              m_pending = 1;
            end else begin
              m_err = 1;
              if (m_cnt < 255) m_cnt++;
            end
            m_have_i = 0; m_have_p = 0; m_have_t = 0;
          end
        endcase
      end
      m_block = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_a", in_a, !m_pending && !m_block);
      check("prog_v", prog_v, m_pending);
      check("err", err, m_err);
      check("err_count", err_count, m_cnt);
      check("prog_gen_idx", prog_gen_idx, r_idx);
      check("prog_period", prog_period, r_per);
      check("prog_ticks", prog_ticks, r_tck);
      check("prog_tag", prog_tag, r_tag);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [1:0] sel, input logic [15:0] pay);
    bit got;
    int n;
    got = 0;
    n = 0;
    in_v = 1'b1;
    in_d = {sel, pay};
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_a;
      tick();
      n++;
    end
    in_v = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL send_timeout: actual=no accept required=accept within 50 cycles");
    end
  endtask

  task automatic send_rec(input logic [15:0] idx, input logic [15:0] per,
                          input logic [15:0] tck, input logic [15:0] tag);
    send_word(FIELD_IDX, idx);
    send_word(FIELD_PERIOD, per);
    send_word(FIELD_TICKS, tck);
    send_word(FIELD_TAG_COMMIT, tag);
  endtask

  task automatic check_rec(input string name, input int idx, input int per,
                           input int tck, input int tag);
    check({name, "_idx"}, prog_gen_idx, idx);
    check({name, "_period"}, prog_period, per);
    check({name, "_ticks"}, prog_ticks, tck);
    check({name, "_tag"}, prog_tag, tag);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    started = 1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_a", in_a, 0);
    check("rst_prog_v", prog_v, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check_rec("rst", 0, 0, 0, 0);
    tick();
    @(negedge clk);
    check("rst_in_a_next", in_a, 1);

    // Record with immediate ack.
    prog_a = 1'b1;
    send_rec(16'd0, 16'd2, 16'd0, 16'd512);
    @(negedge clk);
    check("t1_prog_v", prog_v, 1);
    check("t1_in_a", in_a, 0);
    check_rec("t1", 0, 2, 0, 512);
    tick();
    @(negedge clk);
    check("t1_prog_v_after", prog_v, 0);
    check("t1_in_a_after", in_a, 1);

    // Out-of-order fields, sink stalls 7 cycles while a word is offered.
    prog_a = 1'b0;
    send_word(FIELD_PERIOD, 16'd4);
    send_word(FIELD_TICKS, 16'd2);
    send_word(FIELD_IDX, 16'd1);
    send_word(FIELD_TAG_COMMIT, 16'd513);
    in_v = 1'b1;
    in_d = {FIELD_IDX, 16'd3};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t2_hold_v", prog_v, 1);
      check("t2_hold_in_a", in_a, 0);
      check_rec("t2_hold", 1, 4, 2, 513);
      tick();
    end
    prog_a = 1'b1;
    tick();
    prog_a = 1'b0;
    @(negedge clk);
    check("t2_in_a_back", in_a, 1);
    check("t2_prog_v_done", prog_v, 0);
    send_word(FIELD_IDX, 16'd3);

    // Missing ticks field, then a clean record.
    prog_a = 1'b1;
    send_word(FIELD_PERIOD, 16'd8);
    send_word(FIELD_TAG_COMMIT, 16'd0);
    @(negedge clk);
    check("t3_err", err, 1);
    check("t3_err_count", err_count, 1);
    check("t3_prog_v", prog_v, 0);
    send_rec(16'd2, 16'd8, 16'd3, 16'd100);
    @(negedge clk);
    check("t3_prog_v_ok", prog_v, 1);
    check_rec("t3", 2, 8, 3, 100);
    tick();

    // Fresh start, then four distinct malformed records.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    send_rec(16'd8, 16'd5, 16'd1, 16'd1);
    send_rec(16'd1, 16'd0, 16'd0, 16'd1);
    send_rec(16'd1, 16'd5, 16'd5, 16'd1);
    send_rec(16'd1, 16'd5, 16'd1, 16'h0800);
    @(negedge clk);
    check("t4_err_count", err_count, 4);
    check("t4_prog_v", prog_v, 0);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) send_word(FIELD_TAG_COMMIT, 16'd0);
    @(negedge clk);
    check("t5_err_count", err_count, 255);
    check("t5_err", err, 1);

    // Reset while a record is pending in OUT.
    prog_a = 1'b0;
    send_rec(16'd5, 16'd100, 16'd99, 16'd2047);
    @(negedge clk);
    check("t6_prog_v", prog_v, 1);
    check_rec("t6_pend", 5, 100, 99, 2047);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_rst_prog_v", prog_v, 0);
    check("t6_rst_err_count", err_count, 0);
    check("t6_rst_err", err, 0);
    tick();
    @(negedge clk);
    check("t6_in_a", in_a, 1);
    prog_a = 1'b1;
    send_rec(16'd6, 16'd3, 16'd2, 16'd7);
    @(negedge clk);
    check("t6_new_prog_v", prog_v, 1);
    check_rec("t6_new", 6, 3, 2, 7);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
